// File: rtl/mem_access_pkg.sv
// Shared core types used by the memory-access stage: the executed instruction
// record, the stage's state encoding and its default watchdog limit.
package mem_access_pkg;

  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } Inst;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} MemState;

  localparam int MEM_TIMEOUT_DEFAULT = 1024;
  localparam int MEM_CNT_W_DEFAULT   = 10;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access stage: one aligned 32-bit load or store per enable over a
// ready/valid port, watchdog-guarded, with a one-cycle fin pulse on completion.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W   = MEM_CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        fin,
  input  Inst         inst,
  input  logic [31:0] aluresult,
  input  logic [31:0] result,
  input  logic [31:0] rdata1,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output Inst         inst_out,
  output logic [5:0]  rd,
  output logic        regwrite,
  output logic [31:0] wbdata,
  output logic        fault
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  MemState           state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              fin_reg, fin_next;
  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [31:0]       mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  Inst               inst_reg, inst_next;
  logic              regwrite_reg, regwrite_next;
  logic [31:0]       wbdata_reg, wbdata_next;
  logic              fault_reg, fault_next;
  logic              timed_out;

  assign timed_out = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    fin_next       = 1'b0;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    inst_next      = inst_reg;
    regwrite_next  = regwrite_reg;
    wbdata_next    = wbdata_reg;
    fault_next     = fault_reg;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          inst_next     = inst;
          wbdata_next   = result;
          fault_next    = 1'b0;
          regwrite_next = inst.regwrite;
          if (!(inst.memread || inst.memwrite)) begin
            state_next = DONE;
            fin_next   = 1'b1;
          end else if (is_misaligned(aluresult)) begin
            fault_next    = 1'b1;
            regwrite_next = 1'b0;
            state_next    = DONE;
            fin_next      = 1'b1;
          end else begin
            // memwrite takes precedence when both access flags are set
            state_next     = REQ;
            mem_req_next   = 1'b1;
            mem_we_next    = inst.memwrite;
            mem_addr_next  = aluresult;
            mem_wdata_next = rdata1;
            cnt_next       = '0;
          end
        end
      end

      REQ: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_ready && mem_we_reg) begin
          mem_req_next = 1'b0;
          state_next   = DONE;
          fin_next     = 1'b1;
        end else if (timed_out) begin
          mem_req_next  = 1'b0;
          fault_next    = 1'b1;
          regwrite_next = 1'b0;
          state_next    = DONE;
          fin_next      = 1'b1;
        end else if (mem_ready) begin
          mem_req_next = 1'b0;
          state_next   = WAIT;
        end
      end

      WAIT: begin
        cnt_next = cnt_reg + 1'b1;
        if (mem_rvalid) begin
          wbdata_next = mem_rdata;
          state_next  = DONE;
          fin_next    = 1'b1;
        end else if (timed_out) begin
          fault_next    = 1'b1;
          regwrite_next = 1'b0;
          state_next    = DONE;
          fin_next      = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      fin_reg       <= 1'b0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      inst_reg      <= '0;
      regwrite_reg  <= 1'b0;
      wbdata_reg    <= '0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      fin_reg       <= fin_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      inst_reg      <= inst_next;
      regwrite_reg  <= regwrite_next;
      wbdata_reg    <= wbdata_next;
      fault_reg     <= fault_next;
    end
  end

  assign fin       = fin_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign inst_out  = inst_reg;
  assign rd        = inst_reg.rd;
  assign regwrite  = regwrite_reg;
  assign wbdata    = wbdata_reg;
  assign fault     = fault_reg;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes expected write-back records,
// a negedge monitor pops and compares them on every fin pulse.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fin;
  Inst         inst = '0;
  logic [31:0] aluresult = '0, result = '0, rdata1 = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  Inst         inst_out;
  logic [5:0]  rd;
  logic        regwrite;
  logic [31:0] wbdata;
  logic        fault;

  mem_access #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fin(fin), .inst(inst),
    .aluresult(aluresult), .result(result), .rdata1(rdata1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_out(inst_out), .rd(rd), .regwrite(regwrite), .wbdata(wbdata), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    Inst         inst;
    logic [31:0] wb;
    logic        rw;
    logic        flt;
    int          en_cyc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   fin_cnt = 0;
  int   hs_cnt = 0;
  bit   req_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares each fin pulse against the oldest outstanding expectation
  always @(negedge clk) begin
    if (mem_req) req_seen = 1;
    if (mem_req && mem_ready) hs_cnt++;
    if (fin) begin
      fin_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_fin", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_wbdata"}, 64'(wbdata), 64'(e.wb));
        check({e.name, "_rd"}, 64'(rd), 64'(e.inst.rd));
        check({e.name, "_regwrite"}, 64'(regwrite), 64'(e.rw));
        check({e.name, "_fault"}, 64'(fault), 64'(e.flt));
        check({e.name, "_inst_out"}, 64'(inst_out), 64'(e.inst));
        check({e.name, "_latency"}, 64'(cyc - e.en_cyc), 64'(e.lat));
        $display("txn %s: wbdata=0x%08h rd=%0d regwrite=%0b fault=%0b latency=%0d",
                 e.name, wbdata, rd, regwrite, fault, cyc - e.en_cyc);
      end
    end
  end

  function automatic Inst mk(input logic [5:0] r, input logic rw, input logic mr, input logic mw);
    Inst i;
    i.opcode = 8'h33; i.rd = r; i.regwrite = rw; i.memread = mr; i.memwrite = mw;
    return i;
  endfunction

  // Drives a one-cycle enable; returns at #1 after the sampling edge
  task automatic issue(input string name, input Inst i, input logic [31:0] a,
                       input logic [31:0] r, input logic [31:0] d, input logic [31:0] ewb,
                       input logic erw, input logic eflt, input int lat, input bit push);
    exp_t e;
    inst = i; aluresult = a; result = r; rdata1 = d;
    e.name = name; e.inst = i; e.wb = ewb; e.rw = erw; e.flt = eflt;
    e.en_cyc = cyc; e.lat = lat;
    if (push) exp_q.push_back(e);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int target);
    int n;
    n = 0;
    while (fin_cnt < target && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (fin_cnt < target) check({name, "_fin_timeout"}, 64'(fin_cnt), 64'(target));
    @(posedge clk); #1;
  endtask

  initial begin
    int h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fin", 64'(fin), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_wbdata", 64'(wbdata), 64'd0);
    check("reset_inst_out", 64'(inst_out), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory instruction
    req_seen = 0;
    issue("alu", mk(6'd5, 1'b1, 1'b0, 1'b0), 32'h0, 32'h0000_002A, 32'h0, 32'h2A, 1'b1, 1'b0, 1, 1);
    wait_fin("alu", 1);
    check("alu_no_req", 64'(req_seen), 64'd0);

    // Store with ready held low three cycles
    h0 = hs_cnt;
    issue("store", mk(6'd0, 1'b0, 1'b0, 1'b1), 32'h100, 32'h104, 32'hDEADBEEF, 32'h104, 1'b0, 1'b0, 5, 1);
    for (int k = 0; k < 4; k++) begin
      check("store_req", 64'({mem_req, mem_we}), 64'b11);
      check("store_addr", 64'(mem_addr), 64'h100);
      check("store_wdata", 64'(mem_wdata), 64'hDEADBEEF);
      mem_ready = (k == 3);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    check("store_req_dropped", 64'(mem_req), 64'd0);
    wait_fin("store", 2);
    check("store_one_handshake", 64'(hs_cnt - h0), 64'd1);

    // Load: ready immediately, rvalid two cycles after enable-sampling
    issue("load", mk(6'd7, 1'b1, 1'b1, 1'b0), 32'h200, 32'h0, 32'h0, 32'h12345678, 1'b1, 1'b0, 4, 1);
    check("load_req", 64'({mem_req, mem_we}), 64'b10);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    wait_fin("load", 3);

    // Misaligned load
    req_seen = 0;
    issue("misaligned", mk(6'd4, 1'b1, 1'b1, 1'b0), 32'h203, 32'h55, 32'h0, 32'h55, 1'b0, 1'b1, 1, 1);
    wait_fin("misaligned", 4);
    check("misaligned_no_req", 64'(req_seen), 64'd0);

    // Watchdog: ready stuck low, then a normal instruction
    issue("timeout", mk(6'd9, 1'b1, 1'b1, 1'b0), 32'h300, 32'h77, 32'h0, 32'h77, 1'b0, 1'b1, 9, 1);
    wait_fin("timeout", 5);
    check("timeout_req_dropped", 64'(mem_req), 64'd0);
    issue("after_timeout", mk(6'd3, 1'b1, 1'b0, 1'b0), 32'h0, 32'h99, 32'h0, 32'h99, 1'b1, 1'b0, 1, 1);
    wait_fin("after_timeout", 6);

    // Reset while waiting for load data, then a stray rvalid
    issue("reset_wait", mk(6'd8, 1'b1, 1'b1, 1'b0), 32'h400, 32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 0, 0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wait_mem_req", 64'(mem_req), 64'd0);
    check("rst_wait_outputs", 64'({fin, regwrite, fault, rd}), 64'd0);
    check("rst_wait_wbdata", 64'(wbdata), 64'd0);
    check("rst_wait_addr", 64'(mem_addr), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stray_rvalid_no_fin", 64'(fin_cnt), 64'd6);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the executed instruction, its ALU/FPU result and the store data; performs at most one 32-bit load or store over a ready/valid data-memory port; hands the instruction and write-back value to the write-back stage.
- Sequenced by the core controller through an enable/fin pair, like every other stage; memory latency is variable and guarded by a watchdog.

Parameters:
- TIMEOUT, 1024, max cycles spent in REQ plus WAIT for one access before aborting with fault.
- CNT_W, 10, width of the watchdog counter; must satisfy 2**CNT_W >= TIMEOUT.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous reset, active-high
- enable  in  1  one-cycle start pulse from the controller; sampled only in IDLE
- fin  out  1  one-cycle done pulse; outputs below are valid from this cycle until the next accepted enable
- inst  in  Inst  executed instruction (uses rd, regwrite, memread, memwrite)
- aluresult  in  32  effective address
- result  in  32  ALU/FPU result, the write-back value for non-loads
- rdata1  in  32  store data
- mem_req  out  1  request valid
- mem_we  out  1  1 = store, 0 = load
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  store data
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- inst_out  out  Inst  registered copy of inst
- rd  out  6  destination register = inst_out.rd
- regwrite  out  1  inst_out.regwrite, forced 0 on fault
- wbdata  out  32  load data or result
- fault  out  1  1 = misaligned access or timeout; valid with fin

Behaviour:
- Reset: state = IDLE; fin, mem_req, mem_we, regwrite, fault = 0; mem_addr, mem_wdata, wbdata, rd, counter = 0; inst_out = all-zero Inst.
- Reset mid-access drops mem_req in the next cycle and discards the access. A late mem_rvalid after reset is ignored.
- On enable in IDLE, latch inst, aluresult, result and rdata1, then classify:
  - Neither memread nor memwrite: go to DONE. wbdata = result, fin one cycle later. Total latency 1 cycle.
  - aluresult[1:0] != 0 with memread or memwrite: no request; go to DONE with fault = 1 and regwrite = 0.
  - Otherwise go to REQ. mem_req = 1, mem_we = memwrite, mem_addr = aluresult, mem_wdata = rdata1. Counter cleared.
- If memread and memwrite are both set, memwrite wins (treated as a store).
- REQ: mem_req and payload are held stable until mem_ready. On handshake (mem_req & mem_ready), drop mem_req next cycle.
  - Store: go to DONE.
  - Load: go to WAIT.
- WAIT: on mem_rvalid, wbdata = mem_rdata, go to DONE. mem_rvalid arriving in the same cycle as the handshake is not accepted; loads need rvalid at least 1 cycle after the handshake.
- Minimum latencies from enable to fin:
  - Store with immediate ready: 2 cycles.
  - Load with ready, then rvalid one cycle later: 3 cycles.
- Watchdog: the counter increments every cycle in REQ or WAIT. On reaching TIMEOUT-1 without completion, drop mem_req, set fault = 1, set regwrite = 0, go to DONE.
- DONE: fin = 1 for exactly one cycle, then IDLE. Outputs hold their values until the next accepted enable.
- enable while not in IDLE is ignored; the controller never issues it.
- mem_rvalid in IDLE, REQ or DONE is ignored.

Decomposition:
- Inst already lives in def.sv; memwrite is a field of Inst there.
- Add to the shared package:
  - typedef enum logic [1:0] MemState {IDLE, REQ, WAIT, DONE};
  - localparam MEM_TIMEOUT_DEFAULT.
- No sub-module; the watchdog counter and the FSM stay in one always_ff block.

Test Plan:
- Non-memory inst (regwrite = 1, rd = 5, result = 0x0000_002A), enable -> fin 1 cycle later, wbdata = 0x2A, rd = 5, mem_req never asserted.
- Store, aluresult = 0x100, rdata1 = 0xDEADBEEF, mem_ready held low 3 cycles -> mem_req/addr/wdata stable for 4 cycles, one handshake, fin 1 cycle after the handshake, fault = 0.
- Load, aluresult = 0x200, ready immediate, rvalid 2 cycles later with 0x12345678 -> wbdata = 0x12345678, regwrite = 1, enable-to-fin 4 cycles.
- Load, aluresult = 0x203 -> no mem_req, fin after 1 cycle, fault = 1, regwrite = 0.
- TIMEOUT = 8, mem_ready stuck low -> mem_req dropped, fault = 1, fin 8 cycles after the REQ entry; a following non-memory enable completes normally with fault = 0.
- rst asserted in WAIT -> next cycle all outputs at reset values; a stray mem_rvalid afterwards produces no fin.
